alib_circular_fifo: RTL and testbench

//   Synchronous single-clock circular-buffer FIFO. Stores up to DEPTH words of WIDTH bits in a

---
 rtl/alib_circular_fifo.sv | 64 ++++++
 tb/tb_alib_circular_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alib_circular_fifo.sv
// Single-clock circular-buffer FIFO with registered read data (no fall-through).
// Wrapping read/write pointers over a DEPTH-entry array; occupancy counter drives full/empty.
module alib_circular_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_acc;
  logic             rd_acc;

  // Handshake: a request is taken on the rising edge only when accepted. A read
  // needs a stored word; a write needs a free slot, or a slot freed by a read
  // accepted in the same cycle. Read data appears on data_out after that edge.
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Storage is deliberately not reset; reads are gated so stale words never leak.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alib_circular_fifo.sv
// Bench for alib_circular_fifo: queue-based reference model feeds an expected-data
// queue; an independent monitor pops and compares after every clock edge.
module tb_alib_circular_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: contents in order, plus what the next edge should show.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             pend_rd = 1'b0;
  logic             pend_rst = 1'b1;
  logic             exp_full = 1'b0;
  logic             exp_empty = 1'b1;
  logic [WIDTH-1:0] last_out = '0;
  logic             mon_en = 1'b1;

  alib_circular_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT state just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (pend_rst) begin
        last_out = '0;
        check("reset_data_out", 32'(data_out), 32'(last_out));
      end else if (pend_rd) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          last_out = exp_q.pop_front();
          check("read_data", 32'(data_out), 32'(last_out));
        end
      end else begin
        check("data_hold", 32'(data_out), 32'(last_out));
      end
      check("full", 32'(full), 32'(exp_full));
      check("empty", 32'(empty), 32'(exp_empty));
    end
  end

  // Driver: applies one cycle of stimulus and advances the model to match.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic rs);
    logic ra;
    logic wa;
    @(negedge clk);
    rst = rs;
    wr_en = w;
    rd_en = r;
    data_in = d;
    pend_rst = rs;
    pend_rd = 1'b0;
    if (rs) begin
      model_q.delete();
    end else begin
      ra = r && (model_q.size() != 0);
      wa = w && ((model_q.size() < DEPTH) || ra);
      if (ra) begin
        exp_q.push_back(model_q.pop_front());
        pend_rd = 1'b1;
      end
      if (wa) model_q.push_back(d);
    end
    exp_full = (model_q.size() == DEPTH);
    exp_empty = (model_q.size() == 0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] seed_bytes[3];
    logic [WIDTH-1:0] b;
    seed_bytes[0] = 8'h24;
    seed_bytes[1] = 8'h81;
    seed_bytes[2] = 8'h09;

    // Reset held two edges with requests asserted.
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    idle();

    // Fill, then an ignored write when full.
    for (int i = 0; i < DEPTH; i++) begin
      b = (i < 3) ? seed_bytes[i] : WIDTH'($urandom_range(0, 255));
      step(1'b1, 1'b0, b, 1'b0);
    end
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    idle();

    // Drain, then a read on empty which must hold data_out.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    idle();

    // Wrap-around: offset pointers by 10, then fill and drain with 0x00..0x0F.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, WIDTH'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b0);
    idle();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);
    idle();

    // Simultaneous access at 5 entries.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(8'h40 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WIDTH'(8'h50 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, 1'b0);
    // Simultaneous at full: new word ends up last.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(8'h60 + i), 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);
    // Simultaneous at empty: only the write happens.
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    idle();

    // Mid-operation reset.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, WIDTH'($urandom_range(0, 255)), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    idle();

    // Randomized traffic with varying bias and rare resets.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      step(($urandom_range(0, 9) < 3 + 2 * bias) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7 - 2 * bias) ? 1'b1 : 1'b0,
           WIDTH'($urandom_range(0, 255)),
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    while (model_q.size() != 0) step(1'b0, 1'b1, '0, 1'b0);
    idle();
    idle();

    @(negedge clk);
    mon_en = 1'b0;
    if (exp_q.size() != 0) check("exp_q_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
